// File: rtl/booth_mul_hs.sv
// Radix-4 Booth multiplier with 4-phase request/acknowledge operand and result channels.
// One operation in flight; WIDTH/2+1 digit cycles per product, signed or unsigned per operation.
module booth_mul_hs #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_0r,
  output logic                 in_0a,
  input  logic [WIDTH-1:0]     x_0d,
  input  logic [WIDTH-1:0]     y_0d,
  input  logic                 sgn_0d,
  output logic                 z_0r,
  input  logic                 z_0a,
  output logic [2*WIDTH-1:0]   z_0d
);

  localparam int unsigned NDIG = WIDTH / 2 + 1;
  localparam int unsigned AW   = 2 * WIDTH + 4;
  localparam int unsigned YW   = WIDTH + 3;
  localparam int unsigned CW   = $clog2(NDIG + 1);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_width_check
    $error("booth_mul_hs: WIDTH must be even and >= 4");
  end

  typedef enum logic [1:0] {IDLE, CALC, OUT_REQ, OUT_RTZ} state_e;

  state_e              state_q, state_d;
  logic                in_a_q, in_a_d;
  logic                z_r_q, z_r_d;
  logic [2*WIDTH-1:0]  z_q, z_d;
  logic [AW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [AW-1:0]       acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]       x_ext;
  logic [YW-1:0]       y_ext;
  logic [AW-1:0]       pp;
  logic [AW-1:0]       acc_sum;
  logic                capture;

  // Operands extended to WIDTH+2 bits; multiplier carries the implicit y[-1]=0 in its LSB.
  always_comb begin
    x_ext = {{(AW - WIDTH){sgn_0d & x_0d[WIDTH-1]}}, x_0d};
    y_ext = {{2{sgn_0d & y_0d[WIDTH-1]}}, y_0d, 1'b0};
  end

  // Booth digit select; x_q is pre-shifted so the partial product is already aligned.
  always_comb begin
    pp = '0;
    case (y_q[2:0])
      3'b001, 3'b010: pp = x_q;
      3'b011:         pp = x_q << 1;
      3'b100:         pp = -(x_q << 1);
      3'b101, 3'b110: pp = -x_q;
      default:        pp = '0;
    endcase
    acc_sum = acc_q + pp;
  end

  always_comb begin
    state_d = state_q;
    in_a_d  = in_a_q;
    z_r_d   = z_r_q;
    z_d     = z_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    capture = 1'b0;

    // Input acknowledge returns to zero independently of the FSM.
    if (!in_0r) in_a_d = 1'b0;

    case (state_q)
      IDLE: capture = in_0r & ~in_a_q;
      CALC: begin
        acc_d = acc_sum;
        x_d   = x_q << 2;
        y_d   = y_q >> 2;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(NDIG - 1)) begin
          z_d     = acc_sum[2*WIDTH-1:0];
          z_r_d   = 1'b1;
          state_d = OUT_REQ;
        end
      end
      OUT_REQ: begin
        if (z_0a) begin
          z_r_d   = 1'b0;
          state_d = OUT_RTZ;
        end
      end
      OUT_RTZ: begin
        if (!z_0a) begin
          state_d = IDLE;
          capture = in_0r & ~in_a_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      x_d     = x_ext;
      y_d     = y_ext;
      acc_d   = '0;
      cnt_d   = '0;
      in_a_d  = 1'b1;
      state_d = CALC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      in_a_q  <= 1'b0;
      z_r_q   <= 1'b0;
      z_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      in_a_q  <= in_a_d;
      z_r_q   <= z_r_d;
      z_q     <= z_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_0a = in_a_q;
  assign z_0r  = z_r_q;
  assign z_0d  = z_q;

endmodule

// File: tb/tb_booth_mul_hs.sv
// Directed and randomised checks of booth_mul_hs at WIDTH=8 and WIDTH=16.
module tb_booth_mul_hs;

  logic clk;
  logic rst_n;

  logic        in_r8, in_a8, s8, z_r8, z_a8;
  logic [7:0]  x8, y8;
  logic [15:0] z_d8;

  logic        in_r16, in_a16, s16, z_r16, z_a16;
  logic [15:0] x16, y16;
  logic [31:0] z_d16;

  int n_tests = 0;
  int n_fail  = 0;
  int zpulse8 = 0;
  int cap8    = 0;

  booth_mul_hs #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_0r(in_r8), .in_0a(in_a8), .x_0d(x8), .y_0d(y8), .sgn_0d(s8),
    .z_0r(z_r8), .z_0a(z_a8), .z_0d(z_d8)
  );

  booth_mul_hs #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_0r(in_r16), .in_0a(in_a16), .x_0d(x16), .y_0d(y16), .sgn_0d(s16),
    .z_0r(z_r16), .z_0a(z_a16), .z_0d(z_d16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge z_r8)  zpulse8++;
  always @(posedge in_a8) cap8++;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic        s;
    logic [15:0] exp;
  } vec8_t;

  vec8_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_in_a(input bit w);
    return w ? in_a16 : in_a8;
  endfunction

  function automatic logic get_z_r(input bit w);
    return w ? z_r16 : z_r8;
  endfunction

  function automatic logic [31:0] get_z_d(input bit w);
    return w ? z_d16 : 32'(z_d8);
  endfunction

  // Present operands, wait for the acknowledge, then return-to-zero and scramble operands.
  task automatic req(input bit w, input logic [15:0] x, input logic [15:0] y, input logic s,
                     output int lat_a);
    if (w) begin x16 = x; y16 = y; s16 = s; in_r16 = 1'b1; end
    else   begin x8 = x[7:0]; y8 = y[7:0]; s8 = s; in_r8 = 1'b1; end
    lat_a = 0;
    while (!get_in_a(w) && lat_a < 50) begin tick(); lat_a++; end
    if (w) begin in_r16 = 1'b0; x16 = ~x16; y16 = ~y16; s16 = ~s16; end
    else   begin in_r8 = 1'b0; x8 = ~x8; y8 = ~y8; s8 = ~s8; end
  endtask

  task automatic wait_z(input bit w, output int lat_z);
    lat_z = 0;
    while (!get_z_r(w) && lat_z < 50) begin tick(); lat_z++; end
  endtask

  task automatic ack(input bit w);
    int n;
    n = 0;
    if (w) z_a16 = 1'b1; else z_a8 = 1'b1;
    while (get_z_r(w) && n < 50) begin tick(); n++; end
    check("z_r_fall", 32'(get_z_r(w)), 32'd0);
    if (w) z_a16 = 1'b0; else z_a8 = 1'b0;
    tick();
  endtask

  task automatic op(input bit w, input logic [15:0] x, input logic [15:0] y, input logic s,
                    output logic [31:0] z, output int lat_a, output int lat_z);
    req(w, x, y, s, lat_a);
    wait_z(w, lat_z);
    z = get_z_d(w);
    ack(w);
  endtask

  initial begin
    logic [31:0] z;
    int la, lz, p0, c0, bad;
    logic [15:0] xr, yr;
    logic signed [31:0] xs, ys;
    logic [31:0] xu, yu, ex;

    tbl[0]  = '{8'd15,  8'd5,   1'b0, 16'h004B};
    tbl[1]  = '{8'd5,   8'd15,  1'b0, 16'h004B};
    tbl[2]  = '{8'd0,   8'd10,  1'b0, 16'h0000};
    tbl[3]  = '{8'd10,  8'd0,   1'b0, 16'h0000};
    tbl[4]  = '{8'd200, 8'd2,   1'b0, 16'h0190};
    tbl[5]  = '{8'd2,   8'd200, 1'b0, 16'h0190};
    tbl[6]  = '{8'd200, 8'd2,   1'b1, 16'hFF90};
    tbl[7]  = '{8'h80,  8'h80,  1'b1, 16'h4000};
    tbl[8]  = '{8'h7F,  8'h80,  1'b1, 16'hC080};
    tbl[9]  = '{8'hFF,  8'hFF,  1'b0, 16'hFE01};
    tbl[10] = '{8'hFF,  8'hFF,  1'b1, 16'h0001};
    tbl[11] = '{8'h80,  8'h7F,  1'b1, 16'hC080};

    rst_n = 1'b0;
    in_r8 = 1'b0;  x8 = '0;  y8 = '0;  s8 = 1'b0;  z_a8 = 1'b0;
    in_r16 = 1'b0; x16 = '0; y16 = '0; s16 = 1'b0; z_a16 = 1'b0;

    tick();
    check("rst_in_a8",  32'(in_a8),  32'd0);
    check("rst_z_r8",   32'(z_r8),   32'd0);
    check("rst_z_d8",   32'(z_d8),   32'd0);
    check("rst_in_a16", 32'(in_a16), 32'd0);
    check("rst_z_r16",  32'(z_r16),  32'd0);
    check("rst_z_d16",  z_d16,       32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    p0 = zpulse8;
    for (int i = 0; i < 12; i++) begin
      op(1'b0, 16'(tbl[i].x), 16'(tbl[i].y), tbl[i].s, z, la, lz);
      check($sformatf("vec%0d_z", i), z, 32'(tbl[i].exp));
      check($sformatf("vec%0d_lat_a", i), 32'(la), 32'd1);
      check($sformatf("vec%0d_lat_z", i), 32'(lz), 32'd5);
      if (i == 5) check("six_pulses", 32'(zpulse8 - p0), 32'd6);
    end

    // Request held high for 20 clocks: single capture, acknowledge held until release.
    c0 = cap8;
    bad = 0;
    x8 = 8'd3; y8 = 8'd7; s8 = 1'b0; in_r8 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (!in_a8) bad++;
    end
    check("hold_in_a_high", 32'(bad), 32'd0);
    check("hold_one_capture", 32'(cap8 - c0), 32'd1);
    check("hold_z_r", 32'(z_r8), 32'd1);
    check("hold_z", 32'(z_d8), 32'h0015);
    in_r8 = 1'b0;
    tick();
    check("hold_in_a_fall", 32'(in_a8), 32'd0);
    ack(1'b0);

    // Result acknowledge delayed 10 clocks with a new request pending.
    req(1'b0, 16'd4, 16'd6, 1'b0, la);
    wait_z(1'b0, lz);
    check("stall_lat_z", 32'(lz), 32'd5);
    c0 = cap8;
    bad = 0;
    x8 = 8'd1; y8 = 8'd1; s8 = 1'b0; in_r8 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (!z_r8 || z_d8 !== 16'h0018 || in_a8) bad++;
    end
    check("stall_hold", 32'(bad), 32'd0);
    z_a8 = 1'b1;
    tick();
    check("stall_z_r_low", 32'(z_r8), 32'd0);
    check("stall_rtz_no_cap", 32'(in_a8), 32'd0);
    z_a8 = 1'b0;
    tick();
    check("stall_cap_on_exit", 32'(in_a8), 32'd1);
    check("stall_one_capture", 32'(cap8 - c0), 32'd1);
    in_r8 = 1'b0;
    wait_z(1'b0, lz);
    check("stall2_lat_z", 32'(lz), 32'd5);
    check("stall2_z", 32'(z_d8), 32'h0001);
    ack(1'b0);

    // Reset pulse during the third digit aborts the operation.
    x8 = 8'd12; y8 = 8'd13; s8 = 1'b0; in_r8 = 1'b1;
    tick();
    tick();
    tick();
    check("pre_rst_in_a", 32'(in_a8), 32'd1);
    rst_n = 1'b0;
    in_r8 = 1'b0;
    #1;
    check("arst_in_a", 32'(in_a8), 32'd0);
    check("arst_z_r",  32'(z_r8),  32'd0);
    check("arst_z_d",  32'(z_d8),  32'd0);
    tick();
    rst_n = 1'b1;
    p0 = zpulse8;
    repeat (10) tick();
    check("abort_no_result", 32'(zpulse8 - p0), 32'd0);
    op(1'b0, 16'd9, 16'd9, 1'b0, z, la, lz);
    check("post_rst_z", z, 32'h0051);
    check("post_rst_lat_a", 32'(la), 32'd1);
    check("post_rst_lat_z", 32'(lz), 32'd5);

    op(1'b1, 16'h8000, 16'hFFFF, 1'b1, z, la, lz);
    check("w16_z", z, 32'h00008000);
    check("w16_lat_a", 32'(la), 32'd1);
    check("w16_lat_z", 32'(lz), 32'd9);

    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 1000; k++) begin
        xr = 16'($urandom);
        yr = 16'($urandom);
        if (m == 1) begin
          xs = $signed(xr);
          ys = $signed(yr);
          ex = xs * ys;
        end else begin
          xu = 32'(xr);
          yu = 32'(yr);
          ex = xu * yu;
        end
        op(1'b1, xr, yr, m[0], z, la, lz);
        check($sformatf("w16_rand_m%0d_x%0h_y%0h", m, xr, yr), z, ex);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_mul_hs.md
Name: booth_mul_hs

Overview:
- Parametrised, clocked radix-4 Booth multiplier with 4-phase (return-to-zero) request/acknowledge channels, succeeding the fixed 8-bit Balsa booth multiplier.
- Adds a WIDTH parameter, full 2*WIDTH-bit product and per-operation signed/unsigned mode.
- Sits between a synchronous operand producer and a result consumer.
- One operation in flight; input channel acknowledged at capture so the producer can return-to-zero during compute.

Parameters:
- WIDTH, 8, operand width in bits. Must be even and >=4; violation triggers an elaboration-time error.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_0r  in  1  operand channel request.
- in_0a  out  1  operand channel acknowledge.
- x_0d  in  WIDTH  multiplicand, valid while in_0r=1.
- y_0d  in  WIDTH  multiplier, valid while in_0r=1.
- sgn_0d  in  1  1 = two's-complement operands, 0 = unsigned; sampled with x/y.
- z_0r  out  1  result channel request.
- z_0a  in  1  result channel acknowledge.
- z_0d  out  2*WIDTH  product, stable while z_0r=1 and held afterwards.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_0a=0, z_0r=0, z_0d=0, all internal registers cleared.
- Reset mid-operation aborts the operation; no result is issued.
- FSM states: IDLE, CALC, OUT_REQ, OUT_RTZ.
- Capture: at an edge where state=IDLE, in_0r=1 and in_0a=0:
  - register x, y and sgn;
  - set in_0a=1;
  - go to CALC, digit counter=0, accumulator=0.
- Input return-to-zero is independent of the FSM:
  - in_0a falls at the first edge where in_0r is sampled 0.
  - No new capture while in_0a=1, so a held in_0r never causes a double capture.
- Operand extension to WIDTH+2 bits: sign-extend when sgn=1, zero-extend when sgn=0. Multiplier gets an implicit bit y[-1]=0.
- CALC: N = WIDTH/2+1 cycles, one radix-4 digit per cycle, LSB digit first.
  - Digit from triplet {y[2i+1], y[2i], y[2i-1]}: 000/111 -> 0; 001/010 -> +X; 011 -> +2X; 100 -> -2X; 101/110 -> -X.
  - Accumulator is 2*WIDTH+4 bits; partial product shifted by 2i.
- Exit CALC: on the Nth CALC edge, z_0d <= accumulator[2*WIDTH-1:0] including the final digit, z_0r <= 1, state=OUT_REQ.
  - Result: z_0r rises exactly N clocks after in_0a rises (WIDTH=8: 5 clocks).
- OUT_REQ: hold z_0r=1 and z_0d. When z_0a is sampled 1: z_0r <= 0, state=OUT_RTZ.
- OUT_RTZ: when z_0a is sampled 0, state=IDLE.
  - A new capture can happen in the same edge that leaves OUT_RTZ only if in_0r=1 and in_0a=0; otherwise it is taken in IDLE on a later edge.
- Product is exact for all inputs; no overflow possible in 2*WIDTH bits, including signed min*min (WIDTH=8: -128*-128 = 0x4000).
- z_0a=1 while in IDLE/CALC is ignored.
- z_0d changes only on entry to OUT_REQ.
- Operand changes after capture have no effect.

Test Plan:
- WIDTH=8, sgn=0, x=15, y=5 -> z_0d=0x004B; in_0a rises 1 clk after capture edge; z_0r rises exactly 5 clks after in_0a.
- WIDTH=8, sequence (15,5),(5,15),(0,10),(10,0),(200,2),(2,200) with sgn=0, TB completing full 4-phase cycles -> 0x004B, 0x004B, 0x0000, 0x0000, 0x0190, 0x0190; exactly six z_0r pulses.
- WIDTH=8, sgn=1: (200,2) -> 0xFF90 (-112); (0x80,0x80) -> 0x4000; (0x7F,0x80) -> 0xC080; sgn=0, (0xFF,0xFF) -> 0xFE01.
- Handshake stalls:
  - in_0r held high for 20 clks -> single capture, in_0a stays 1 until in_0r falls.
  - z_0a delayed 10 clks -> z_0r and z_0d held, no new capture accepted until OUT_RTZ completes.
- rst_n pulsed low for 1 clk during CALC (digit 2) -> in_0a, z_0r and z_0d are 0 immediately (asynchronously); next operation (9,9) -> 0x0051 with normal latency.
- WIDTH=16, sgn=1, x=0x8000, y=0xFFFF -> 0x00008000; z_0r rises 9 clks after in_0a; random 1000 ops per mode match the reference model.
